// File: rtl/crc32c_pkg.sv
//------------------------------------------------------------------------------
// Module      : crc32c_pkg
// Description : Shared CRC-32C constants, FSM encodings and the reflected
//               single-byte update function.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package crc32c_pkg;

    localparam logic [31:0] CRC32C_POLY_REFL = 32'h82F63B78;
    localparam logic [31:0] CRC32C_RESIDUE   = 32'hB798B438;
    localparam logic [31:0] CRC32C_INIT_DEF  = 32'hFFFFFFFF;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_accum = 1'b1;

    // Reflected update: the byte enters at the register LSB, one shift per bit.
    function automatic logic [31:0] crc32c_byte(input logic [31:0] crc,
                                                input logic [7:0]  data);
        logic [31:0] r;
        r = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32C_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc32c_bytes_comb.sv
//------------------------------------------------------------------------------
// Module      : crc32c_bytes_comb
// Description : Combinational chain of NBYTES byte steps; exposes the CRC after
//               every byte so a partial last beat can pick its tap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc32c_bytes_comb
    import crc32c_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NBYTES = DATA_W / 8
) (
    input  logic [31:0]          crc_in,
    input  logic [DATA_W-1:0]    data,
    output logic [NBYTES*32-1:0] crc_steps
);

    logic [31:0] w_chain [0:NBYTES];

    assign w_chain[0] = crc_in;

    // Slice k of crc_steps holds the CRC after bytes 0..k.
    generate
        for (genvar i = 0; i < NBYTES; i++) begin : g_byte
            assign w_chain[i+1]         = crc32c_byte(w_chain[i], data[8*i +: 8]);
            assign crc_steps[32*i +: 32] = w_chain[i+1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/crc32c_stream.sv
//------------------------------------------------------------------------------
// Module      : crc32c_stream
// Description : Streaming CRC-32C engine with partial last beat and registered
//               valid/ready result. Define CRC32C_CHECK_EN to add m_good.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc32c_stream
    import crc32c_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [31:0] INIT   = CRC32C_INIT_DEF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
    localparam int NBYTES = DATA_W / 8,
    localparam int CNT_W  = $clog2(NBYTES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic [CNT_W-1:0]  s_bytes,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_crc
`ifdef CRC32C_CHECK_EN
    ,
    output logic              m_good
`endif
);

    localparam logic [CNT_W-1:0] c_nbytes = CNT_W'(NBYTES);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [31:0]         r_crc;
    logic                w_accept;
    logic [31:0]         w_base;
    logic [NBYTES*32-1:0] w_steps;
    logic [31:0]         w_full;
    logic [31:0]         w_part;
    logic [CNT_W-1:0]    w_eff;

    crc32c_bytes_comb #(
        .DATA_W (DATA_W)
    ) u_chain (
        .crc_in    (w_base),
        .data      (s_data),
        .crc_steps (w_steps)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = s_eop ? c_st_idle : c_st_accum;
        end
    end

    // Output / datapath control
    always_comb begin
        s_ready  = ~m_valid | m_ready;
        w_accept = s_valid & s_ready;
        // A beat arriving with no packet open starts one implicitly.
        w_base   = (s_sop || (r_state == c_st_idle)) ? INIT : r_crc;
    end

    // Out-of-range byte counts collapse to a full beat.
    always_comb begin
        w_eff = s_bytes;
        if ((s_bytes == '0) || (s_bytes > c_nbytes)) begin
            w_eff = c_nbytes;
        end
    end

    always_comb begin
        w_full = w_steps[32*(NBYTES-1) +: 32];
        w_part = w_full;
        for (int k = 1; k <= NBYTES; k++) begin
            if (w_eff == CNT_W'(k)) begin
                w_part = w_steps[32*(k-1) +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= INIT;
        end else if (w_accept) begin
            r_crc <= s_eop ? INIT : w_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_crc   <= 32'h00000000;
        end else if (w_accept && s_eop) begin
            m_valid <= 1'b1;
            m_crc   <= w_part ^ XOROUT;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef CRC32C_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_good <= 1'b0;
        end else if (w_accept && s_eop) begin
            m_good <= (w_part == CRC32C_RESIDUE);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc32c_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_crc32c_stream
// Description : Scoreboard bench for crc32c_stream (DATA_W=32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_crc32c_stream;

    localparam int DATA_W = 32;
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sop;
    logic              s_eop;
    logic [CNT_W-1:0]  s_bytes;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_crc;
`ifdef CRC32C_CHECK_EN
    logic              m_good;
`endif

    always #5 clk = ~clk;

    crc32c_stream #(
        .DATA_W (DATA_W),
        .INIT   (32'hFFFFFFFF),
        .XOROUT (32'hFFFFFFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sop   (s_sop),
        .s_eop   (s_eop),
        .s_bytes (s_bytes),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_crc   (m_crc)
`ifdef CRC32C_CHECK_EN
        ,
        .m_good  (m_good)
`endif
    );

    typedef struct packed {
        logic [31:0] crc;
        logic        good;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   rdy_mode = 0;
    int   rdy_idx  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Bit-serial reference, LSB-first over the byte stream.
    function automatic logic [31:0] model(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'h82F63B78;
            end
        end
        return ~c;
    endfunction

    // Monitor: pops the scoreboard whenever a result is consumed.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_crc;
        logic        exp_rdy;
        exp_t        e;
        prev_stall = 1'b0;
        prev_crc   = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_m_valid", {31'h0, m_valid}, 32'h1);
                    chk("hold_m_crc", m_crc, prev_crc);
                end
                exp_rdy = ~m_valid | m_ready;
                chk("s_ready", {31'h0, s_ready}, {31'h0, exp_rdy});
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %08h expected none", m_crc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_crc", m_crc, e.crc);
`ifdef CRC32C_CHECK_EN
                        chk("m_good", {31'h0, m_good}, {31'h0, e.good});
`endif
                    end
                end
                prev_stall = m_valid & ~m_ready;
                prev_crc   = m_crc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rdy_idx++;
        case (rdy_mode)
            1:       m_ready = ((rdy_idx % 3) != 1);
            2:       m_ready = ($urandom_range(0, 2) != 0);
            default: ;
        endcase
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] data, input logic sop, input logic eop,
                             input logic [CNT_W-1:0] nb, input logic [31:0] ecrc,
                             input logic egood);
        bit ok;
        int guard;
        exp_t e;
        s_valid = 1'b1;
        s_data  = data;
        s_sop   = sop;
        s_eop   = eop;
        s_bytes = nb;
        ok      = 1'b0;
        guard   = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            step();
            guard++;
        end while (!ok && guard < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready=0 expected 1 within 100 cycles");
        end else if (eop) begin
            e.crc  = ecrc;
            e.good = egood;
            exp_q.push_back(e);
            chk("latency_m_valid", {31'h0, m_valid}, 32'h1);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b[$], input logic [31:0] ecrc, input logic egood,
                               input bit use_sop, input int bytes_ovr, input bit gaps);
        int nb, nbeats, rem, idx;
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  cnt;
        logic last;
        nb     = b.size();
        nbeats = (nb + NBYTES - 1) / NBYTES;
        for (int bt = 0; bt < nbeats; bt++) begin
            for (int k = 0; k < NBYTES; k++) begin
                idx = bt * NBYTES + k;
                d[8*k +: 8] = (idx < nb) ? b[idx] : 8'hA5;
            end
            last = (bt == nbeats - 1);
            rem  = nb - bt * NBYTES;
            cnt  = last ? ((bytes_ovr >= 0) ? CNT_W'(bytes_ovr) : CNT_W'(rem)) : CNT_W'(1);
            if (gaps) repeat ($urandom_range(0, 2)) step();
            send_beat(d, use_sop && (bt == 0), last, cnt, ecrc, egood);
        end
    endtask

    task automatic drain();
        int guard;
        rdy_mode = 0;
        m_ready  = 1'b1;
        guard    = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 100) begin
            step();
            guard++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] digits[$];
        logic [7:0] pkt[$];
        logic [31:0] mc;

        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  digits[$];
        logic [7:0]  pkt[$];
        logic [31:0] mc;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        s_bytes = '0;
        m_ready = 1'b1;
        repeat (3) step();
        chk("reset_m_valid", {31'h0, m_valid}, 32'h0);
        chk("reset_m_crc", m_crc, 32'h0);
        chk("reset_s_ready", {31'h0, s_ready}, 32'h1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) digits.push_back(8'(8'h31 + i));

        // "123456789" with explicit sop
        send_packet(digits, 32'hE3069283, 1'b0, 1'b1, -1, 1'b0);
        drain();

        // Same digits plus their little-endian CRC -> residue
        pkt = digits;
        pkt.push_back(8'h83); pkt.push_back(8'h92); pkt.push_back(8'h06); pkt.push_back(8'hE3);
        send_packet(pkt, 32'h48674BC7, 1'b1, 1'b1, -1, 1'b0);
        drain();

        // 32 x 0x00 with s_bytes=0 on the last beat, 32 x 0xFF with s_bytes=7
        pkt.delete();
        for (int i = 0; i < 32; i++) pkt.push_back(8'h00);
        send_packet(pkt, 32'h8A9136AA, 1'b0, 1'b1, 0, 1'b0);
        pkt.delete();
        for (int i = 0; i < 32; i++) pkt.push_back(8'hFF);
        send_packet(pkt, 32'h62A8AB43, 1'b0, 1'b1, 7, 1'b0);
        drain();

        // Implicit start from IDLE without sop
        send_packet(digits, 32'hE3069283, 1'b0, 1'b0, -1, 1'b0);
        drain();

        // Open packet abandoned by a new sop
        send_beat(32'hDEADBEEF, 1'b1, 1'b0, '0, 32'h0, 1'b0);
        send_beat(32'h01234567, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        send_packet(digits, 32'hE3069283, 1'b0, 1'b1, -1, 1'b0);
        drain();

        // Reset mid-packet
        send_beat(32'hCAFEF00D, 1'b1, 1'b0, '0, 32'h0, 1'b0);
        send_beat(32'h55AA55AA, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        chk("midrst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("midrst_m_crc", m_crc, 32'h0);
        chk("midrst_s_ready", {31'h0, s_ready}, 32'h1);
        rst = 1'b0;
        send_packet(digits, 32'hE3069283, 1'b0, 1'b0, -1, 1'b0);
        drain();

        // Back-to-back single-beat packets while m_ready toggles 1,0,1
        rdy_mode = 1;
        for (int p = 0; p < 12; p++) begin
            pkt.delete();
            for (int k = 0; k < 4; k++) pkt.push_back(8'($urandom_range(0, 255)));
            mc = model(pkt);
            send_packet(pkt, mc, ((mc ^ 32'hFFFFFFFF) == 32'hB798B438), 1'b1, -1, 1'b0);
        end
        drain();

        // Random lengths with random gaps and random m_ready
        rdy_mode = 2;
        for (int p = 0; p < 8; p++) begin
            pkt.delete();
            for (int k = 0; k < $urandom_range(1, 40); k++) pkt.push_back(8'($urandom_range(0, 255)));
            mc = model(pkt);
            send_packet(pkt, mc, ((mc ^ 32'hFFFFFFFF) == 32'hB798B438), 1'b1, -1, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
